// File: rtl/dcache_miss_responder_if.sv
// Miss-request type and the cache/bus signal bundle shared by dcache_miss_responder and its initiators.
package dcache_miss_pkg;
  localparam int CACHE_LINE_WIDTH = 64;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [1:0]  size;
    logic        we;
    logic [31:0] wdata;
    logic        bypass;
  } miss_req_t;

  typedef enum logic {SINGLE_REQ, CACHE_LINE_REQ} req_t;
endpackage

interface dcache_miss_responder_if;
  import dcache_miss_pkg::*;

  miss_req_t   miss_req_i;
  logic        miss_gnt_o;
  logic        resp_valid_o;
  logic [63:0] resp_data_o;
  logic        resp_err_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output miss_req_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  miss_gnt_o, resp_valid_o, resp_data_o, resp_err_o,
           mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
  );

  modport slave (
    input  miss_req_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output miss_gnt_o, resp_valid_o, resp_data_o, resp_err_o,
           mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_miss_responder.sv
// Turns dcache miss requests into 32-bit bus beats and returns one assembled response.
// Optional bus-wait timeout with error response: define MISS_RESP_TIMEOUT_EN.
//
// state | meaning
// IDLE  | accepting a miss request (miss_gnt_o follows valid)
// REQ   | address phase on the bus, held until mem_gnt_i
// WAIT  | waiting for mem_rvalid_i of the current beat
// RESP  | one-cycle response pulse to the cache
module dcache_miss_responder
  import dcache_miss_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LINE_BEATS     = CACHE_LINE_WIDTH / 32
) (
  input logic                   clk_i,
  input logic                   rst_i,
  dcache_miss_responder_if.slave io
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                      state_q, state_d;
  req_t                        kind_q, kind_d;
  logic [29:0]                 waddr_q, waddr_d;
  logic                        we_q, we_d;
  logic [3:0]                  be_q, be_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic                        beat_q, beat_d;
  logic [LINE_BEATS-1:0][31:0] line_q, line_d;
  logic                        last_beat;
  logic                        err_resp;

`ifdef MISS_RESP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Byte enables of an uncached access must match its size and byte offset.
  function automatic logic be_matches(input logic [1:0] size, input logic [1:0] ofs,
                                      input logic [3:0] be);
    logic ok;
    case (size)
      2'd0:    ok = (be == (4'b0001 << ofs));
      2'd1:    ok = (be == (ofs[1] ? 4'b1100 : 4'b0011));
      2'd2:    ok = (be == 4'b1111);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  always_comb begin
    if (!rst_i && state_q == IDLE && io.miss_req_i.valid && io.miss_req_i.bypass)
      assert (be_matches(io.miss_req_i.size, io.miss_req_i.addr[1:0], io.miss_req_i.be));
  end

  assign last_beat = (kind_q == SINGLE_REQ) || (int'(beat_q) == LINE_BEATS - 1);

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    waddr_d = waddr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    beat_d  = beat_q;
    line_d  = line_q;
`ifdef MISS_RESP_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        beat_d = 1'b0;
        if (io.miss_req_i.valid) begin
          state_d = REQ;
          if (io.miss_req_i.bypass) begin
            kind_d  = SINGLE_REQ;
            waddr_d = io.miss_req_i.addr[31:2];
            we_d    = io.miss_req_i.we;
            be_d    = io.miss_req_i.be;
            wdata_d = io.miss_req_i.wdata;
          end else begin
            // Line refills are always full-word reads from the line base.
            kind_d  = CACHE_LINE_REQ;
            waddr_d = {io.miss_req_i.addr[31:3], 1'b0};
            we_d    = 1'b0;
            be_d    = 4'hF;
            wdata_d = '0;
          end
        end
      end
      REQ: begin
        if (io.mem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (io.mem_rvalid_i) begin
          line_d[beat_q] = io.mem_rdata_i;
          if (last_beat) begin
            state_d = RESP;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef MISS_RESP_TIMEOUT_EN
    if (state_q == IDLE) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (state_q == REQ || state_q == WAIT) begin
      if (io.mem_gnt_i || io.mem_rvalid_i) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        cnt_d   = '0;
        err_d   = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      kind_q  <= SINGLE_REQ;
      waddr_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      beat_q  <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
    end
  end

`ifdef MISS_RESP_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_resp = err_q;
`else
  assign err_resp = 1'b0;
`endif

  // Bus and response outputs are forced to zero outside their owning state.
  always_comb begin
    io.miss_gnt_o   = (state_q == IDLE) && io.miss_req_i.valid && !rst_i;
    io.mem_req_o    = (state_q == REQ);
    io.mem_addr_o   = '0;
    io.mem_we_o     = 1'b0;
    io.mem_be_o     = '0;
    io.mem_wdata_o  = '0;
    io.resp_valid_o = (state_q == RESP);
    io.resp_data_o  = '0;
    io.resp_err_o   = 1'b0;
    if (state_q == REQ) begin
      io.mem_addr_o  = {waddr_q[29:1], waddr_q[0] | beat_q, 2'b00};
      io.mem_we_o    = we_q;
      io.mem_be_o    = be_q;
      io.mem_wdata_o = wdata_q;
    end
    if (state_q == RESP) begin
      io.resp_err_o = err_resp;
      if (err_resp)
        io.resp_data_o = '0;
      else if (kind_q == CACHE_LINE_REQ)
        io.resp_data_o = line_q;
      else if (we_q)
        io.resp_data_o = '0;
      else
        io.resp_data_o = {32'h0, line_q[0]};
    end
  end

endmodule

// File: tb/tb_dcache_miss_responder.sv
// Randomized bench for dcache_miss_responder: per-transaction expectations derived from the beat/latency rules.
module tb_dcache_miss_responder;
  import dcache_miss_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_miss_responder_if bus();

  dcache_miss_responder #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"},    {63'h0, bus.mem_req_o},    64'h0);
    chk({tag, "_addr"},   {32'h0, bus.mem_addr_o},   64'h0);
    chk({tag, "_rvalid"}, {63'h0, bus.resp_valid_o}, 64'h0);
    chk({tag, "_rdata"},  bus.resp_data_o,           64'h0);
    chk({tag, "_rerr"},   {63'h0, bus.resp_err_o},   64'h0);
  endtask

  // IDLE cycle with no request, optionally with stray bus pulses that must be ignored.
  task automatic idle_cycle(input bit stray);
    @(negedge clk);
    bus.miss_req_i.valid = 1'b0;
    bus.mem_gnt_i        = stray & $urandom_range(0, 1);
    bus.mem_rvalid_i     = stray;
    bus.mem_rdata_i      = $urandom;
    #1;
    chk_quiet("idle");
    chk("idle_gnt", {63'h0, bus.miss_gnt_o}, 64'h0);
  endtask

  // One complete transaction starting in an IDLE cycle; expected bus beats, response data and
  // response cycle follow from the request type and the chosen bus wait counts.
  task automatic txn(input logic bypass, input logic [31:0] addr, input logic [3:0] be,
                     input logic [1:0] size, input logic we, input logic [31:0] wdata,
                     input int gwait, input int rwait, input bit hold,
                     input logic [31:0] rd0, input logic [31:0] rd1);
    miss_req_t   r;
    int          nb;
    logic [31:0] ea [2];
    logic [31:0] rd [2];
    logic [63:0] exp_resp;
    nb    = bypass ? 1 : 2;
    ea[0] = bypass ? (addr & 32'hFFFF_FFFC) : (addr & 32'hFFFF_FFF8);
    ea[1] = ea[0] + 32'd4;
    rd[0] = rd0;
    rd[1] = rd1;
    if (!bypass)      exp_resp = {rd1, rd0};
    else if (we)      exp_resp = 64'h0;
    else              exp_resp = {32'h0, rd0};

    r = '{valid: 1'b1, addr: addr, be: be, size: size, we: we, wdata: wdata, bypass: bypass};
    @(negedge clk);
    bus.miss_req_i   = r;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    #1;
    chk("grant", {63'h0, bus.miss_gnt_o}, 64'h1);
    chk("grant_noreq", {63'h0, bus.mem_req_o}, 64'h0);

    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k <= gwait; k++) begin
        @(negedge clk);
        bus.miss_req_i.valid = hold;
        bus.mem_gnt_i        = (k == gwait);
        bus.mem_rvalid_i     = (k != gwait) && ($urandom_range(0, 3) == 0);
        bus.mem_rdata_i      = $urandom;
        #1;
        chk("mem_req", {63'h0, bus.mem_req_o}, 64'h1);
        chk("mem_addr", {32'h0, bus.mem_addr_o}, {32'h0, ea[b]});
        chk("mem_we", {63'h0, bus.mem_we_o}, {63'h0, bypass & we});
        chk("mem_be", {60'h0, bus.mem_be_o}, {60'h0, bypass ? be : 4'hF});
        if (bypass) chk("mem_wdata", {32'h0, bus.mem_wdata_o}, {32'h0, wdata});
        chk("busy_gnt", {63'h0, bus.miss_gnt_o}, 64'h0);
        chk("early_resp", {63'h0, bus.resp_valid_o}, 64'h0);
      end
      for (int k = 0; k <= rwait; k++) begin
        @(negedge clk);
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = (k == rwait);
        bus.mem_rdata_i  = (k == rwait) ? rd[b] : $urandom;
        #1;
        chk("wait_noreq", {63'h0, bus.mem_req_o}, 64'h0);
        chk("busy_gnt", {63'h0, bus.miss_gnt_o}, 64'h0);
        chk("early_resp", {63'h0, bus.resp_valid_o}, 64'h0);
      end
    end

    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    #1;
    chk("resp_valid", {63'h0, bus.resp_valid_o}, 64'h1);
    chk("resp_data", bus.resp_data_o, exp_resp);
    chk("resp_err", {63'h0, bus.resp_err_o}, 64'h0);
    chk("resp_gnt", {63'h0, bus.miss_gnt_o}, 64'h0);
    chk("resp_noreq", {63'h0, bus.mem_req_o}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic        by;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [3:0]  be;

    bus.miss_req_i   = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;

    repeat (3) @(negedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_gnt", {63'h0, bus.miss_gnt_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycle(1'b1);

    // Reset during the address phase of a line refill.
    @(negedge clk);
    bus.miss_req_i = '{valid: 1'b1, addr: 32'h8000_0010, be: 4'hF, size: 2'd2,
                       we: 1'b0, wdata: 32'h0, bypass: 1'b0};
    #1;
    chk("abort_grant", {63'h0, bus.miss_gnt_o}, 64'h1);
    @(negedge clk);
    bus.miss_req_i.valid = 1'b0;
    #1;
    chk("abort_req", {63'h0, bus.mem_req_o}, 64'h1);
    chk("abort_addr", {32'h0, bus.mem_addr_o}, 64'h8000_0010);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_quiet("abort");
    chk("abort_be", {60'h0, bus.mem_be_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) idle_cycle(1'b1);

    txn(1'b1, 32'h1000_0006, 4'b1100, 2'd1, 1'b0, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF, 32'h0);
    idle_cycle(1'b0);
    txn(1'b0, 32'h2000_001C, 4'hF, 2'd2, 1'b0, 32'h0, 0, 0, 1'b0, 32'h1111_1111, 32'h2222_2222);
    idle_cycle(1'b0);
    txn(1'b1, 32'h3000_0000, 4'h1, 2'd0, 1'b1, 32'hA5A5_A5A5, 3, 0, 1'b1, $urandom, 32'h0);
    idle_cycle(1'b0);

    // Valid held high across consecutive transactions.
    txn(1'b1, 32'h4000_0008, 4'hF, 2'd2, 1'b0, 32'h0, 1, 1, 1'b1, $urandom, 32'h0);
    txn(1'b0, 32'h4000_0100, 4'hF, 2'd2, 1'b1, 32'h5, 0, 2, 1'b1, $urandom, $urandom);
    txn(1'b1, 32'h4000_0203, 4'h8, 2'd0, 1'b1, 32'h77, 0, 0, 1'b0, $urandom, 32'h0);
    idle_cycle(1'b1);

    for (int i = 0; i < 40; i++) begin
      by = 1'($urandom_range(0, 1));
      a  = $urandom;
      sz = 2'($urandom_range(0, 2));
      if (by) begin
        case (sz)
          2'd0:    be = 4'b0001 << a[1:0];
          2'd1:    be = a[1] ? 4'hC : 4'h3;
          default: be = 4'hF;
        endcase
      end else begin
        be = 4'($urandom);
      end
      txn(by, a, be, sz, 1'($urandom_range(0, 1)), $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          $urandom, $urandom);
      if ($urandom_range(0, 1) == 1) idle_cycle(1'($urandom_range(0, 1)));
    end
    idle_cycle(1'b0);

`ifdef MISS_RESP_TIMEOUT_EN
    @(negedge clk);
    bus.miss_req_i = '{valid: 1'b1, addr: 32'h5000_0000, be: 4'hF, size: 2'd2,
                       we: 1'b0, wdata: 32'h0, bypass: 1'b1};
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    #1;
    chk("to_grant", {63'h0, bus.miss_gnt_o}, 64'h1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.miss_req_i.valid = 1'b0;
      #1;
      chk("to_req", {63'h0, bus.mem_req_o}, 64'h1);
      chk("to_early", {63'h0, bus.resp_valid_o}, 64'h0);
    end
    @(negedge clk);
    #1;
    chk("to_resp", {63'h0, bus.resp_valid_o}, 64'h1);
    chk("to_err", {63'h0, bus.resp_err_o}, 64'h1);
    chk("to_data", bus.resp_data_o, 64'h0);
    chk("to_noreq", {63'h0, bus.mem_req_o}, 64'h0);
    repeat (3) idle_cycle(1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_miss_responder.md
Name: dcache_miss_responder

Overview:
- Memory-side responder for data-cache miss requests of type miss_req_t.
- Converts each accepted request into 32-bit memory-bus beats:
  - a single beat for bypass (uncached) accesses;
  - two beats for a 64-bit cache-line refill.
- Returns one assembled response to the cache miss handler.
- Sits between the dcache miss handler (initiator) and the core's 32-bit data memory port.

Parameters:
- TIMEOUT_CYCLES, 255: bus-wait cycles before an error response is produced. Used only with the optional feature.
- LINE_BEATS, 2: 32-bit beats per cache line. Fixed at CACHE_LINE_WIDTH/32 and not overridable in practice.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- miss_req_i  in  73  miss_req_t {valid, addr[31:0], be[3:0], size[1:0], we, wdata[31:0], bypass}
- miss_gnt_o  out  1  request accepted this cycle
- resp_valid_o  out  1  one-cycle response pulse
- resp_data_o  out  64  refill line, or single word in [31:0]
- resp_err_o  out  1  response carries an error (timeout)
- mem_req_o  out  1  bus request
- mem_addr_o  out  32  bus word address
- mem_we_o  out  1  bus write
- mem_be_o  out  4  bus byte enables
- mem_wdata_o  out  32  bus write data
- mem_gnt_i  in  1  bus accepted the address phase
- mem_rvalid_i  in  1  bus data/ack phase
- mem_rdata_i  in  32  bus read data

Behaviour:
- Reset: all outputs 0, FSM in IDLE, beat counter 0, line buffer 0. Reset mid-transaction aborts it immediately; no response is issued.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - miss_gnt_o = miss_req_i.valid (combinational).
  - On valid, latch the request and go to REQ.
  - Classify the request:
    - bypass=1 → single request (req_t SINGLE_REQ).
    - bypass=0 → CACHE_LINE_REQ.
- REQ:
  - mem_req_o=1, address/we/be/wdata held stable until mem_gnt_i.
  - On mem_gnt_i, go to WAIT and drop mem_req_o the next cycle.
- WAIT:
  - On mem_rvalid_i, store mem_rdata_i into line buffer word [beat].
  - If this was the last beat, go to RESP. Otherwise increment beat and return to REQ.
  - mem_rvalid_i in the same cycle as mem_gnt_i is not legal.
  - mem_rvalid_i outside WAIT is ignored.
- RESP:
  - resp_valid_o=1 for exactly one cycle, then return to IDLE.
  - No backpressure from the cache side.
  - miss_gnt_o is 0 in every state except IDLE, so at most one request is outstanding.
- Single request:
  - mem_addr_o = {addr[31:2],2'b00}; be, we and wdata are passed through unchanged; size is used only to check be.
  - Read: resp_data_o = {32'b0, rdata}.
  - Write: resp_data_o = 0; the response marks completion after the bus ack.
- Cache-line request:
  - Always a read; we is ignored.
  - Beat 0 at {addr[31:3],3'b000}, beat 1 at beat-0 address + 4; mem_be_o = 4'hF.
  - resp_data_o = {beat1, beat0}.
- Latency with zero-wait bus (gnt in the REQ cycle, rvalid the cycle after):
  - single request: 4 cycles from grant to resp_valid_o;
  - line request: 6 cycles.
- resp_data_o and resp_err_o are valid only while resp_valid_o=1 and are held 0 otherwise.
- Beat counter is 1 bit and wraps to 0 on every entry to IDLE.

Optional Feature:
- Macro: MISS_RESP_TIMEOUT_EN.
- With the macro defined:
  - A counter increments each cycle in REQ or WAIT and clears on any mem_gnt_i or mem_rvalid_i.
  - When the counter reaches TIMEOUT_CYCLES, go to RESP with resp_err_o=1 and resp_data_o=0, and drop mem_req_o.
  - Late bus responses are ignored until the next REQ.
- Without the macro: no counter exists, resp_err_o is tied 0, and the block waits indefinitely.

Test Plan:
- Reset during REQ of a line refill (addr 0x8000_0010) → all outputs 0 next edge; no resp_valid_o; the next request is accepted normally.
- Bypass read, addr 0x1000_0006, be 4'b1100, rdata 0xDEAD_BEEF → mem_addr_o 0x1000_0004, be 4'b1100; resp_data_o 0x0000_0000_DEAD_BEEF after 4 cycles.
- Line refill, addr 0x2000_001C, rdata 0x1111_1111 then 0x2222_2222 → bus addrs 0x2000_0018 and 0x2000_001C; resp_data_o 0x2222_2222_1111_1111; single resp pulse.
- Bypass write, addr 0x3000_0000, wdata 0xA5A5_A5A5, be 4'h1, gnt delayed 3 cycles → address phase held stable 4 cycles; mem_we_o=1; resp_data_o 0; miss_gnt_o stays 0 until back in IDLE.
- Back-to-back requests with valid held high → second grant only in the cycle after resp_valid_o; no overlap of bus transactions.
- MISS_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_gnt_i never asserted → resp_valid_o with resp_err_o=1 on the 8th wait cycle; a later stray mem_rvalid_i has no effect.
